// File: rtl/ir_pkg.sv
// IR line-sensor sequencer shared types.
// States, channel map and reading slot indices.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    WAIT,
    PUBLISH
  } ir_state_t;

  typedef logic [11:0] ir_rd_t;

  localparam int IDX_R0 = 0;
  localparam int IDX_L0 = 1;
  localparam int IDX_R1 = 2;
  localparam int IDX_L1 = 3;
  localparam int IDX_R2 = 4;
  localparam int IDX_L2 = 5;
  localparam int IDX_R3 = 6;
  localparam int IDX_L3 = 7;

  localparam logic [2:0] CHNL_MAP [0:7] = '{
    3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7, 3'd6, 3'd5
  };

endpackage

// File: rtl/ir_sense_timer.sv
// Loadable down-counter for settle and timeout intervals.
// expired is high in the CYC-th cycle after a load.
module ir_sense_timer #(
  parameter int CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int W = (CYC > 1) ? $clog2(CYC) : 1;

  logic [W-1:0] cnt;

  // load to CYC-1, then count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYC - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ir_sense_seq.sv
// IR emitter / A2D sequencer for the line sensors.
// Collects eight readings and publishes them atomically.
module ir_sense_seq
  import ir_pkg::*;
#(
  parameter int PERIOD_CYC  = 4096,
  parameter int SETTLE_CYC  = 1024,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cnv_cmplt,
  input  logic [11:0]  res,
  output logic         strt_cnv,
  output logic [2:0]   chnnl,
  output logic         IR_en,
  output logic         IR_vld,
  output logic [11:0]  IR_R0,
  output logic [11:0]  IR_R1,
  output logic [11:0]  IR_R2,
  output logic [11:0]  IR_R3,
  output logic [11:0]  IR_L0,
  output logic [11:0]  IR_L1,
  output logic [11:0]  IR_L2,
  output logic [11:0]  IR_L3,
  output logic         timeout_err
);

  localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  ir_state_t     st;
  ir_state_t     nxt;
  logic [PW-1:0] per_cnt;
  logic [2:0]    idx;
  ir_rd_t        stg [0:7];
  ir_rd_t        pub [0:7];

  logic settle_ld;
  logic settle_exp;
  logic to_ld;
  logic to_exp;
  logic cap;
  logic to_set;
  logic pub_en;

  ir_sense_timer #(.CYC(SETTLE_CYC)) u_settle (
    .clk     (clk),
    .rst     (rst),
    .load    (settle_ld),
    .expired (settle_exp)
  );

  ir_sense_timer #(.CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (to_ld),
    .expired (to_exp)
  );

  // free-running round period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (per_cnt == PW'(PERIOD_CYC - 1)) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      st <= nxt;
    end
  end

  // next state and A2D / emitter controls
  always_comb begin
    nxt       = st;
    settle_ld = 1'b0;
    to_ld     = 1'b0;
    cap       = 1'b0;
    to_set    = 1'b0;
    pub_en    = 1'b0;
    strt_cnv  = 1'b0;
    chnnl     = 3'd0;
    IR_en     = 1'b0;
    unique case (st)
      IDLE: begin
        if (per_cnt == '0) begin
          nxt       = SETTLE;
          settle_ld = 1'b1;
        end
      end
      SETTLE: begin
        IR_en = 1'b1;
        if (settle_exp) begin
          nxt = START;
        end
      end
      START: begin
        IR_en    = 1'b1;
        strt_cnv = 1'b1;
        chnnl    = CHNL_MAP[idx];
        to_ld    = 1'b1;
        nxt      = WAIT;
      end
      WAIT: begin
        IR_en = 1'b1;
        chnnl = CHNL_MAP[idx];
        if (cnv_cmplt) begin
          cap = 1'b1;
          nxt = (idx == 3'd7) ? PUBLISH : START;
        end else if (to_exp) begin
          to_set = 1'b1;
          nxt    = IDLE;
        end
      end
      PUBLISH: begin
        IR_en  = 1'b1;
        pub_en = 1'b1;
        nxt    = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // channel index: restart each settle, step after each capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (st == SETTLE) begin
      idx <= '0;
    end else if (cap && idx != 3'd7) begin
      idx <= idx + 1'b1;
    end
  end

  // staging slot is chosen by idx, never by chnnl
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) stg[i] <= '0;
    end else if (cap) begin
      stg[idx] <= res;
    end
  end

  // atomic publish of a complete set plus its strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) pub[i] <= '0;
      IR_vld <= 1'b0;
    end else begin
      IR_vld <= pub_en;
      if (pub_en) begin
        for (int i = 0; i < 8; i++) pub[i] <= stg[i];
      end
    end
  end

  // sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (to_set) begin
      timeout_err <= 1'b1;
    end
  end

  assign IR_R0 = pub[IDX_R0];
  assign IR_L0 = pub[IDX_L0];
  assign IR_R1 = pub[IDX_R1];
  assign IR_L1 = pub[IDX_L1];
  assign IR_R2 = pub[IDX_R2];
  assign IR_L2 = pub[IDX_L2];
  assign IR_R3 = pub[IDX_R3];
  assign IR_L3 = pub[IDX_L3];

endmodule

// File: tb/tb_ir_sense_seq.sv
// Directed bench for ir_sense_seq.
// A2D model answers 20 clocks after strt_cnv.
module tb_ir_sense_seq;

  logic        clk;
  logic        rst;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        IR_en;
  logic        IR_vld;
  logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3;
  logic [11:0] IR_L0, IR_L1, IR_L2, IR_L3;
  logic        timeout_err;

  ir_sense_seq dut (
    .clk         (clk),
    .rst         (rst),
    .cnv_cmplt   (cnv_cmplt),
    .res         (res),
    .strt_cnv    (strt_cnv),
    .chnnl       (chnnl),
    .IR_en       (IR_en),
    .IR_vld      (IR_vld),
    .IR_R0       (IR_R0),
    .IR_R1       (IR_R1),
    .IR_R2       (IR_R2),
    .IR_R3       (IR_R3),
    .IR_L0       (IR_L0),
    .IR_L1       (IR_L1),
    .IR_L2       (IR_L2),
    .IR_L3       (IR_L3),
    .timeout_err (timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // model configuration (written by tests only)
  bit          fixed_en  = 0;
  logic [11:0] fixed_val = '0;
  int          hold_idx  = -1;
  int          late_idx  = -1;
  bit          spur_en   = 0;

  // model state (written by model only)
  int          n_strt = 0;
  int          k_round = 0;
  bit          busy = 0;
  int          cd = 0;
  logic [2:0]  cur_ch = '0;
  logic [11:0] cur_res = '0;
  bit          glitch = 0;
  logic [2:0]  ch_log [0:7];
  int          t_strt [0:7];

  logic [2:0] exp_ch [0:7] = '{3'd1, 3'd0, 3'd4, 3'd2,
                                3'd3, 3'd7, 3'd6, 3'd5};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] rd(input int i);
    case (i)
      0: rd = IR_R0;
      1: rd = IR_L0;
      2: rd = IR_R1;
      3: rd = IR_L1;
      4: rd = IR_R2;
      5: rd = IR_L2;
      6: rd = IR_R3;
      default: rd = IR_L3;
    endcase
  endfunction

  // A2D model, sampled and driven on the falling edge
  initial begin
    cnv_cmplt = 0;
    res = '0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 0;
      if (!IR_en) k_round = 0;
      if (rst) begin
        busy = 0;
      end else if (busy) begin
        if (chnnl !== cur_ch) glitch = 1;
        cd = cd - 1;
        if (cd == 0) begin
          busy = 0;
          cnv_cmplt = 1;
          res = cur_res;
        end
      end else if (strt_cnv) begin
        cur_ch = chnnl;
        if (k_round < 8) begin
          ch_log[k_round] = chnnl;
          t_strt[k_round] = cyc;
        end
        cur_res = fixed_en ? fixed_val : 12'h100 + 12'(k_round);
        if (k_round != hold_idx) begin
          busy = 1;
          cd = (k_round == late_idx) ? 256 : 20;
        end
        k_round = k_round + 1;
        n_strt = n_strt + 1;
      end else if (spur_en && k_round == 0 && (cyc % 37) == 0) begin
        cnv_cmplt = 1;
        res = 12'hBAD;
      end
    end
  end

  task automatic wait_vld(input int lim, output int t, output bit ok);
    ok = 0;
    t = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (IR_vld === 1'b1) begin
        ok = 1;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({strt_cnv, chnnl, IR_en, IR_vld, timeout_err} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 0",
               {strt_cnv, chnnl, IR_en, IR_vld, timeout_err});
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd(i) !== 12'h000) begin
        n_bad++;
        $display("FAIL reset_rd%0d: got %h want 000", i, rd(i));
      end
    end
    rst = 0;
  endtask

  task automatic test_round();
    int t_en, t_s, t_v, n0;
    bit ok;
    n0 = n_strt;
    t_en = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (IR_en === 1'b1) begin
        t_en = cyc;
        break;
      end
    end
    n_cmp++;
    if (t_en < 0) begin
      n_bad++;
      $display("FAIL ir_en_rise: got none want rise within 10");
    end
    t_s = -1;
    for (int i = 0; i < 1100; i++) begin
      if (strt_cnv === 1'b1) begin
        t_s = cyc;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (t_s - t_en !== 1024) begin
      n_bad++;
      $display("FAIL settle_len: got %0d want 1024", t_s - t_en);
    end
    wait_vld(2000, t_v, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL round_vld: got no IR_vld want pulse");
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd(i) !== 12'h100 + 12'(i)) begin
        n_bad++;
        $display("FAIL round_rd%0d: got %h want %h", i, rd(i),
                 12'h100 + 12'(i));
      end
    end
    n_cmp++;
    if (n_strt - n0 !== 8) begin
      n_bad++;
      $display("FAIL strt_count: got %0d want 8", n_strt - n0);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (ch_log[i] !== exp_ch[i]) begin
        n_bad++;
        $display("FAIL chnnl%0d: got %0d want %0d", i, ch_log[i], exp_ch[i]);
      end
    end
    n_cmp++;
    if (glitch !== 1'b0) begin
      n_bad++;
      $display("FAIL chnnl_hold: got changed want held");
    end
    @(negedge clk);
    n_cmp++;
    if ({IR_vld, IR_en} !== 2'b00) begin
      n_bad++;
      $display("FAIL after_vld: got vld/en %b want 00", {IR_vld, IR_en});
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    bit ok, stable;
    fixed_en = 1;
    fixed_val = 12'hFFF;
    wait_vld(5000, t1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL b2b_vld1: got no IR_vld want pulse");
    end
    fixed_val = 12'h000;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd(i) !== 12'hFFF) begin
        n_bad++;
        $display("FAIL b2b_r1_rd%0d: got %h want fff", i, rd(i));
      end
    end
    stable = 1;
    ok = 0;
    t2 = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (IR_vld === 1'b1) begin
        ok = 1;
        t2 = cyc;
        break;
      end
      for (int j = 0; j < 8; j++)
        if (rd(j) !== 12'hFFF) stable = 0;
    end
    n_cmp++;
    if (!stable) begin
      n_bad++;
      $display("FAIL b2b_stable: got change want fff held");
    end
    n_cmp++;
    if (!ok || t2 - t1 !== 4096) begin
      n_bad++;
      $display("FAIL b2b_period: got %0d want 4096", ok ? t2 - t1 : -1);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd(i) !== 12'h000) begin
        n_bad++;
        $display("FAIL b2b_r2_rd%0d: got %h want 000", i, rd(i));
      end
    end
  endtask

  task automatic test_spurious_late();
    int t;
    bit ok;
    fixed_en = 0;
    spur_en = 1;
    late_idx = 2;
    wait_vld(5000, t, ok);
    spur_en = 0;
    late_idx = -1;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL spur_vld: got no IR_vld want pulse");
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd(i) !== 12'h100 + 12'(i)) begin
        n_bad++;
        $display("FAIL spur_rd%0d: got %h want %h", i, rd(i),
                 12'h100 + 12'(i));
      end
    end
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL late_accept: got timeout_err %b want 0", timeout_err);
    end
  endtask

  task automatic test_timeout();
    int t_to, t;
    bit ok, saw_vld;
    hold_idx = 3;
    saw_vld = 0;
    ok = 0;
    t_to = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (IR_vld === 1'b1) saw_vld = 1;
      if (timeout_err === 1'b1) begin
        ok = 1;
        t_to = cyc;
        break;
      end
    end
    n_cmp++;
    if (!ok || t_to - t_strt[3] !== 257) begin
      n_bad++;
      $display("FAIL to_time: got %0d want 257",
               ok ? t_to - t_strt[3] : -1);
    end
    n_cmp++;
    if (IR_en !== 1'b0) begin
      n_bad++;
      $display("FAIL to_ir_en: got %b want 0", IR_en);
    end
    n_cmp++;
    if (saw_vld) begin
      n_bad++;
      $display("FAIL to_no_vld: got IR_vld want none");
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd(i) !== 12'h100 + 12'(i)) begin
        n_bad++;
        $display("FAIL to_rd%0d: got %h want %h", i, rd(i),
                 12'h100 + 12'(i));
      end
    end
    hold_idx = -1;
    fixed_en = 1;
    fixed_val = 12'h5A5;
    wait_vld(6000, t, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL to_next_vld: got no IR_vld want pulse");
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd(i) !== 12'h5A5) begin
        n_bad++;
        $display("FAIL to_next_rd%0d: got %h want 5a5", i, rd(i));
      end
    end
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_sticky: got %b want 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    fixed_en = 0;
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #2;
      if (k_round == 6) begin
        ok = 1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL mid_reach: got no idx5 start want one");
    end
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({strt_cnv, chnnl, IR_en, IR_vld, timeout_err} !== 7'd0) begin
      n_bad++;
      $display("FAIL mid_rst_ctl: got %b want 0",
               {strt_cnv, chnnl, IR_en, IR_vld, timeout_err});
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd(i) !== 12'h000) begin
        n_bad++;
        $display("FAIL mid_rst_rd%0d: got %h want 000", i, rd(i));
      end
    end
    repeat (3) @(negedge clk);
    rst = 0;
    wait_vld(6000, t, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL mid_vld: got no IR_vld want pulse");
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd(i) !== 12'h100 + 12'(i)) begin
        n_bad++;
        $display("FAIL mid_rd%0d: got %h want %h", i, rd(i),
                 12'h100 + 12'(i));
      end
    end
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_to_clr: got %b want 0", timeout_err);
    end
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_round();
    test_back_to_back();
    test_spurious_late();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
